car_motor_drv: RTL and testbench



---
 rtl/car_motor_drv_if.sv | 26 ++
 rtl/car_motor_drv.sv | 160 ++++++++++++++++
 tb/tb_car_motor_drv.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/car_motor_drv_if.sv
// Interface bundling the steering commands and the bridge-side outputs of
// the car motor drive stage.
// master: the steering controller side (drives md1..md4).
// slave : the drive stage (drives the bridge pins and FSM state).
interface car_motor_drv_if;
    logic       md1;
    logic       md2;
    logic       md3;
    logic       md4;
    logic       l_in1;
    logic       l_in2;
    logic       r_in1;
    logic       r_in2;
    logic [1:0] l_state;
    logic [1:0] r_state;

    modport master (
        output md1, md2, md3, md4,
        input  l_in1, l_in2, r_in1, r_in2, l_state, r_state
    );

    modport slave (
        input  md1, md2, md3, md4,
        output l_in1, l_in2, r_in1, r_in2, l_state, r_state
    );
endinterface

// File: rtl/car_motor_drv.sv
// car_motor_drv: H-bridge drive stage for the left and right motors.
// A shared free-running PWM counter gates each bridge.
// Each motor has its own FSM (IDLE / RUN / DEAD):
// - RUN ramps the duty up at a controlled rate.
// - Every direction reversal passes through DEAD, with both bridge pins low.
// Optional build macro CAR_MOTOR_BRAKE_EN:
// - IDLE drives both pins high (active brake).
// - RUN->STOP always goes through DEAD, so brake never directly follows drive.
module car_motor_drv #(
    parameter int PWM_BITS = 8,
    parameter int DUTY_MAX = 200,
    parameter int RAMP_DIV = 64,
    parameter int DEAD_CYC = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    car_motor_drv_if.slave bus
);
    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_TOP   = PWM_BITS'(DUTY_MAX);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    // Index 0 is the left motor, index 1 is the right motor.
    logic [1:0] fwd_cmd;
    logic [1:0] rev_cmd;
    assign fwd_cmd = {bus.md3, bus.md1};
    assign rev_cmd = {bus.md4, bus.md2};

    logic [PWM_BITS-1:0] pwm_cnt_reg;

    // Shared PWM time base; wraps naturally at 2**PWM_BITS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm_cnt_reg <= '0;
        else          pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_motor
            state_t              state_reg, state_next;
            logic                dir_reg, dir_next;      // 0 = forward, 1 = reverse
            logic [PWM_BITS-1:0] duty_reg, duty_next;
            logic [PRESC_W-1:0]  presc_reg, presc_next;
            logic [DEAD_W-1:0]   dead_reg, dead_next;
            logic                in1_reg, in2_reg;
            logic                cmd_go;
            logic                cmd_dir;

            // Exactly one of fwd/rev asserted is a drive command; 00 and 11 both mean STOP.
            assign cmd_go  = fwd_cmd[gi] ^ rev_cmd[gi];
            assign cmd_dir = rev_cmd[gi];

            // FSM, ramp and dead-time registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= ST_IDLE;
                    dir_reg   <= 1'b0;
                    duty_reg  <= '0;
                    presc_reg <= '0;
                    dead_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    dir_reg   <= dir_next;
                    duty_reg  <= duty_next;
                    presc_reg <= presc_next;
                    dead_reg  <= dead_next;
                end
            end

            // Next-state logic: ramp while the command matches the latched direction.
            // A reversal waits out the dead window before anything new is accepted.
            always_comb begin
                state_next = state_reg;
                dir_next   = dir_reg;
                duty_next  = duty_reg;
                presc_next = presc_reg;
                dead_next  = dead_reg;
                case (state_reg)
                    ST_IDLE: begin
                        duty_next = '0;
                        if (cmd_go) begin
                            state_next = ST_RUN;
                            dir_next   = cmd_dir;
                            presc_next = '0;
                        end
                    end
                    ST_RUN: begin
                        if (!cmd_go) begin
`ifdef CAR_MOTOR_BRAKE_EN
                            state_next = ST_DEAD;
                            dead_next  = '0;
`else
                            state_next = ST_IDLE;
`endif
                            duty_next  = '0;
                        end else if (cmd_dir != dir_reg) begin
                            state_next = ST_DEAD;
                            dead_next  = '0;
                            duty_next  = '0;
                        end else if (presc_reg == PRESC_LAST) begin
                            presc_next = '0;
                            if (duty_reg < DUTY_TOP) duty_next = duty_reg + PWM_BITS'(1);
                        end else begin
                            presc_next = presc_reg + PRESC_W'(1);
                        end
                    end
                    ST_DEAD: begin
                        duty_next = '0;
                        if (dead_reg == DEAD_LAST) begin
                            if (cmd_go) begin
                                state_next = ST_RUN;
                                dir_next   = cmd_dir;
                                presc_next = '0;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end else begin
                            dead_next = dead_reg + DEAD_W'(1);
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            // Bridge pins registered from the current state: only the active side is PWM-gated.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    in1_reg <= 1'b0;
                    in2_reg <= 1'b0;
                end else if (state_reg == ST_RUN) begin
                    in1_reg <= !dir_reg && (pwm_cnt_reg < duty_reg);
                    in2_reg <= dir_reg && (pwm_cnt_reg < duty_reg);
`ifdef CAR_MOTOR_BRAKE_EN
                end else if (state_reg == ST_IDLE) begin
                    in1_reg <= 1'b1;
                    in2_reg <= 1'b1;
`endif
                end else begin
                    in1_reg <= 1'b0;
                    in2_reg <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.l_in1   = gen_motor[0].in1_reg;
    assign bus.l_in2   = gen_motor[0].in2_reg;
    assign bus.r_in1   = gen_motor[1].in1_reg;
    assign bus.r_in2   = gen_motor[1].in2_reg;
    assign bus.l_state = gen_motor[0].state_reg;
    assign bus.r_state = gen_motor[1].state_reg;
endmodule

// File: tb/tb_car_motor_drv.sv
// Directed testbench for car_motor_drv.
// Test parameters: PWM_BITS=4, DUTY_MAX=12, RAMP_DIV=4, DEAD_CYC=3.
// Timing model:
// - Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// - 'cyc' numbers the rising edges since reset release.
// - The PWM counter equals cyc mod 16 after each edge.
`timescale 1ns/1ps
module tb_car_motor_drv;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    car_motor_drv_if bus();

    car_motor_drv #(
        .PWM_BITS(4),
        .DUTY_MAX(12),
        .RAMP_DIV(4),
        .DEAD_CYC(3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

`ifdef CAR_MOTOR_BRAKE_EN
    localparam logic IDLE_PIN = 1'b1;
`else
    localparam logic IDLE_PIN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Command order: {md1, md2, md3, md4}
    task automatic set_cmd(input logic [3:0] m);
        {bus.md1, bus.md2, bus.md3, bus.md4} = m;
    endtask

    initial begin
        int bad;
        int l_hi;
        int r_hi;
        int rev_hi;

        set_cmd(4'b0000);
        reset_n = 1'b0;
        #12;
        check("reset_pins", {bus.l_in1, bus.l_in2, bus.r_in1, bus.r_in2}, 4'b0000);
        check("reset_states", {bus.l_state, bus.r_state}, 4'b0000);
        #10 reset_n = 1'b1;

        // Idle for 40 cycles with no command.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ({bus.l_in1, bus.l_in2, bus.r_in1, bus.r_in2} !== {4{IDLE_PIN}}) bad++;
            if ({bus.l_state, bus.r_state} !== 4'b0000) bad++;
        end
        check("idle_40_cycles_bad", bad, 0);

        // Forward on both motors for 100 cycles; RUN is entered at edge 41.
        set_cmd(4'b1010);
        l_hi = 0;
        r_hi = 0;
        rev_hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cyc == 41) begin
                check("run_entry_l_state", bus.l_state, 2'b01);
                check("run_entry_r_state", bus.r_state, 2'b01);
            end
            if (cyc == 48) check("ramp_l_in1_e48", bus.l_in1, 1'b0);
            if (cyc == 49) check("ramp_l_in1_e49", bus.l_in1, 1'b1);
            if (cyc == 49) check("ramp_r_in1_e49", bus.r_in1, 1'b1);
            if (cyc == 50) check("ramp_l_in1_e50", bus.l_in1, 1'b1);
            if (cyc == 51) check("ramp_l_in1_e51", bus.l_in1, 1'b0);
            if (cyc >= 42 && (bus.l_in2 || bus.r_in2)) rev_hi++;
            if (cyc >= 90 && cyc <= 105) begin
                l_hi += int'(bus.l_in1);
                r_hi += int'(bus.r_in1);
            end
        end
        check("sat_l_high_of_16", l_hi, 12);
        check("sat_r_high_of_16", r_hi, 12);
        check("fwd_rev_pins_high", rev_hi, 0);
        check("run_l_state_e140", bus.l_state, 2'b01);

        // Reverse the left motor: 3 cycles of DEAD, then a ramp in reverse from duty 0.
        set_cmd(4'b0110);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rev_dead_l_state", bus.l_state, 2'b10);
            check("rev_dead_l_pins", {bus.l_in1, bus.l_in2}, 2'b00);
            check("rev_dead_r_state", bus.r_state, 2'b01);
        end
        tick();
        check("rev_run_l_state_e144", bus.l_state, 2'b01);
        l_hi = 0;
        r_hi = 0;
        rev_hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            rev_hi += int'(bus.l_in2);
            l_hi += int'(bus.l_in1);
            r_hi += int'(bus.r_in1);
        end
        check("rev_ramp_l_in2_early", rev_hi, 0);
        check("rev_l_in1_high", l_hi, 0);
        check("rev_right_unaffected", r_hi, 12);
        tick();
        check("rev_l_in2_first_high_e161", bus.l_in2, 1'b1);

        // md1=md2=1 is treated as STOP.
        set_cmd(4'b1110);
`ifdef CAR_MOTOR_BRAKE_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("brake_dead_l_state", bus.l_state, 2'b10);
            if (i > 0) check("brake_dead_l_pins", {bus.l_in1, bus.l_in2}, 2'b00);
        end
        tick();
        check("brake_idle_l_state", bus.l_state, 2'b00);
        tick();
        check("brake_idle_l_pins", {bus.l_in1, bus.l_in2}, 2'b11);
`else
        tick();
        check("illegal11_l_state", bus.l_state, 2'b00);
        tick();
        check("illegal11_l_pins", {bus.l_in1, bus.l_in2}, 2'b00);
`endif

        // Command toggles inside the dead window: only STOP on the final edge counts.
        set_cmd(4'b1010);
        tick();
        check("dt_run_l_state", bus.l_state, 2'b01);
        set_cmd(4'b0110);
        tick();
        check("dt_dead0_l_state", bus.l_state, 2'b10);
        set_cmd(4'b1010);
        tick();
        check("dt_dead1_l_state", bus.l_state, 2'b10);
        set_cmd(4'b0110);
        tick();
        check("dt_dead2_l_state", bus.l_state, 2'b10);
        check("dt_dead2_l_pins", {bus.l_in1, bus.l_in2}, 2'b00);
        set_cmd(4'b0010);
        tick();
        check("dt_end_l_state", bus.l_state, 2'b00);
        tick();
        check("dt_idle_l_pins", {bus.l_in1, bus.l_in2}, {2{IDLE_PIN}});

        // Reset pulsed mid-ramp, between clock edges.
        set_cmd(4'b1010);
        for (int i = 0; i < 20; i++) tick();
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_pins", {bus.l_in1, bus.l_in2, bus.r_in1, bus.r_in2}, 4'b0000);
        check("async_reset_states", {bus.l_state, bus.r_state}, 4'b0000);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc = 0;
        tick();
        check("post_reset_run_states", {bus.l_state, bus.r_state}, 4'b0101);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            bad += int'(bus.l_in1) + int'(bus.r_in1);
        end
        check("post_reset_ramp_from_zero", bad, 0);
        tick();
        check("post_reset_first_high_e17", {bus.l_in1, bus.r_in1}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
